// File: rtl/core_clock_gen.sv
// ----------------------------------------------------------------------------
// core_clock_gen
//
// Produces the gated, divided clock for the processor core under test. The
// generated clock either free-runs (auto mode) or produces an exact number of
// full periods loaded by the host-side controller (pulse mode), which lets
// the controller single-step or burst-step the core.
//
// Ports
//   clk          system clock, all logic on its rising edge
//   reset        synchronous, active-high reset
//   write_pulse  one-cycle strobe: remaining <= pulse (reload, never add)
//   option       0 = pulse mode, 1 = auto (free-running) mode
//   out_enable   0 forces clk_o low and stops the phase counter
//   divider      half-period length D in clk cycles (0 behaves as 1)
//   pulse        number of core-clock periods N to generate in pulse mode
//   clk_o        registered generated clock
//   busy         high while remaining is non-zero
//   remaining    current remaining-period count
// ----------------------------------------------------------------------------
module core_clock_gen #(
    parameter int COUNTER_BITS = 32,
    parameter int PULSE_BITS   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_pulse,
    input  logic                    option,
    input  logic                    out_enable,
    input  logic [COUNTER_BITS-1:0] divider,
    input  logic [PULSE_BITS-1:0]   pulse,
    output logic                    clk_o,
    output logic                    busy,
    output logic [PULSE_BITS-1:0]   remaining
);

    logic [COUNTER_BITS-1:0] cnt_reg;
    logic [COUNTER_BITS-1:0] half_period;
    logic                    active;
    logic                    counting;
    logic                    phase_end;
    logic                    decrement;
    logic [PULSE_BITS-1:0]   remaining_next;

    always_comb begin
        half_period = (divider == '0) ? COUNTER_BITS'(1) : divider;
        active      = out_enable & (option | (remaining != '0));
        // A high phase always runs to completion once generation stops, so
        // the core never sees a runt high pulse.
        counting    = out_enable & (active | clk_o);
        // >= rather than == so that shrinking the divider mid-phase ends the
        // phase on the next edge instead of wrapping the counter.
        phase_end   = (cnt_reg >= (half_period - COUNTER_BITS'(1)));
        // Only a falling toggle in pulse mode consumes a period; the settling
        // fall after stopping happens with remaining already zero.
        decrement   = counting & phase_end & clk_o & ~option & (remaining != '0);

        remaining_next = remaining;
        if (write_pulse) begin
            remaining_next = pulse;
        end else if (decrement) begin
            remaining_next = remaining - PULSE_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_o     <= 1'b0;
            cnt_reg   <= '0;
            remaining <= '0;
            busy      <= 1'b0;
        end else begin
            if (!out_enable) begin
                clk_o   <= 1'b0;
                cnt_reg <= '0;
            end else if (counting) begin
                if (phase_end) begin
                    clk_o   <= ~clk_o;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + COUNTER_BITS'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
            remaining <= remaining_next;
            busy      <= (remaining_next != '0);
        end
    end

endmodule

// File: tb/tb_core_clock_gen.sv
// ----------------------------------------------------------------------------
// tb_core_clock_gen
//
// Self-checking bench for core_clock_gen. A behavioural reference model
// (level / cycles-spent-in-phase / periods-left) predicts the outputs after
// every clock edge and pushes them into a scoreboard queue; a monitor on the
// falling edge pops and compares. Directed scenarios additionally check
// absolute timing figures with constant expectations.
// ----------------------------------------------------------------------------
module tb_core_clock_gen;

    localparam int CB = 32;
    localparam int PB = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          write_pulse;
    logic          option;
    logic          out_enable;
    logic [CB-1:0] divider;
    logic [PB-1:0] pulse;
    logic          clk_o;
    logic          busy;
    logic [PB-1:0] remaining;

    int tests = 0;
    int fails = 0;
    int cycle_no = 0;

    typedef struct {
        logic          clk_o;
        logic          busy;
        logic [PB-1:0] remaining;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state
    bit          m_level;
    int unsigned m_spent;
    int unsigned m_left;

    always #5 clk = ~clk;

    core_clock_gen #(
        .COUNTER_BITS(CB),
        .PULSE_BITS  (PB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .write_pulse(write_pulse),
        .option     (option),
        .out_enable (out_enable),
        .divider    (divider),
        .pulse      (pulse),
        .clk_o      (clk_o),
        .busy       (busy),
        .remaining  (remaining)
    );

    // One clock edge of the specified behaviour, from the current inputs.
    task automatic model_tick();
        int unsigned half;
        int unsigned left_next;
        bit          generating;
        half = (divider == 0) ? 1 : int'(divider);
        if (reset) begin
            m_level = 1'b0;
            m_spent = 0;
            m_left  = 0;
        end else begin
            left_next  = m_left;
            generating = option || (m_left != 0);
            if (!out_enable) begin
                m_level = 1'b0;
                m_spent = 0;
            end else if (generating || m_level) begin
                m_spent = m_spent + 1;
                if (m_spent >= half) begin
                    if (m_level && !option && m_left != 0)
                        left_next = m_left - 1;
                    m_level = !m_level;
                    m_spent = 0;
                end
            end else begin
                m_spent = 0;
            end
            if (write_pulse)
                left_next = int'(pulse);
            m_left = left_next;
        end
    endtask

    task automatic step();
        exp_t e;
        model_tick();
        e.clk_o     = m_level;
        e.busy      = (m_left != 0);
        e.remaining = PB'(m_left);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: outputs are valid every cycle once expectations exist.
    always @(negedge clk) begin
        cycle_no <= cycle_no + 1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            tests++;
            if (clk_o !== mon_e.clk_o || busy !== mon_e.busy ||
                remaining !== mon_e.remaining) begin
                fails++;
                $display("FAIL scoreboard cycle %0d: got clk_o=%0b busy=%0b remaining=%0d, required clk_o=%0b busy=%0b remaining=%0d",
                         cycle_no, clk_o, busy, remaining,
                         mon_e.clk_o, mon_e.busy, mon_e.remaining);
            end
        end
    end

    initial begin
        int cyc;
        int highs;
        int rises;
        int toggles;
        bit done;
        bit saw_one;
        bit prev;
        int seg_len;

        reset       = 1'b1;
        write_pulse = 1'b0;
        option      = 1'b0;
        out_enable  = 1'b1;
        divider     = '0;
        pulse       = '0;
        repeat (3) step();
        reset = 1'b0;
        check("reset_clk_o", int'(clk_o), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_remaining", int'(remaining), 0);

        // Idle: enabled, pulse mode, nothing loaded
        highs = 0;
        repeat (20) begin
            step();
            if (clk_o || busy) highs++;
        end
        check("idle_quiet", highs, 0);
        $display("[TB] idle: 20 cycles, out_enable=1 option=0");

        // Pulse burst: D=3, N=2 -> 12 cycles, 6 high
        divider = 3; pulse = 2; write_pulse = 1'b1;
        step();
        write_pulse = 1'b0;
        check("burst_loaded", int'(remaining), 2);
        cyc = 0; highs = 0; rises = 0; done = 1'b0; saw_one = 1'b0; prev = clk_o;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            cyc++;
            if (clk_o) highs++;
            if (clk_o && !prev) rises++;
            if (remaining == 1) saw_one = 1'b1;
            prev = clk_o;
            if (!busy) done = 1'b1;
        end
        check("burst_cycles", cyc, 12);
        check("burst_high_cycles", highs, 6);
        check("burst_rises", rises, 2);
        check("burst_saw_one", int'(saw_one), 1);
        check("burst_end_low", int'(clk_o), 0);
        $display("[TB] burst: D=3 N=2 done in %0d cycles", cyc);

        // Auto mode, D=1 then D=0: toggle every cycle, remaining untouched
        option = 1'b1; divider = 1; pulse = 3; write_pulse = 1'b1;
        step();
        write_pulse = 1'b0;
        toggles = 0; prev = clk_o;
        repeat (10) begin
            step();
            if (clk_o != prev) toggles++;
            prev = clk_o;
        end
        check("auto_d1_toggles", toggles, 10);
        check("auto_remaining_kept", int'(remaining), 3);
        divider = 0;
        toggles = 0;
        repeat (10) begin
            step();
            if (clk_o != prev) toggles++;
            prev = clk_o;
        end
        check("auto_d0_toggles", toggles, 10);
        $display("[TB] auto: D=1 and D=0, 10 cycles each");

        // Disable mid-high, then re-enable: full 4-cycle low phase first
        divider = 4;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (clk_o) done = 1'b1;
        end
        check("disable_found_high", int'(done), 1);
        out_enable = 1'b0;
        step();
        check("disable_low", int'(clk_o), 0);
        out_enable = 1'b1;
        cyc = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            cyc++;
            if (clk_o) done = 1'b1;
        end
        check("reenable_low_phase", cyc, 4);
        $display("[TB] disable/enable: D=4, first rise after %0d cycles", cyc);

        // Reload while busy: D=2, N=5, after one period reload N=1
        option = 1'b0; pulse = 0; write_pulse = 1'b1;
        step();
        write_pulse = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (!clk_o) done = 1'b1;
        end
        divider = 2; pulse = 5; write_pulse = 1'b1;
        step();
        write_pulse = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (remaining == 4) done = 1'b1;
        end
        check("reload_first_period", int'(done), 1);
        pulse = 1; write_pulse = 1'b1;
        step();
        write_pulse = 1'b0;
        check("reload_value", int'(remaining), 1);
        rises = 0; highs = 0; done = 1'b0; prev = clk_o;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (clk_o) highs++;
            if (clk_o && !prev) rises++;
            prev = clk_o;
            if (!busy) done = 1'b1;
        end
        check("reload_rises", rises, 1);
        check("reload_high_cycles", highs, 2);
        $display("[TB] reload: D=2 N=5 then N=1, %0d extra period(s)", rises);

        // Mode switch while high: the 5-cycle high phase completes, then low
        option = 1'b1; divider = 5;
        done = 1'b0; prev = clk_o;
        for (int i = 0; i < 30 && !done; i++) begin
            step();
            if (clk_o && !prev) done = 1'b1;
            prev = clk_o;
        end
        check("switch_found_rise", int'(done), 1);
        option = 1'b0;
        cyc = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            cyc++;
            if (!clk_o) done = 1'b1;
        end
        check("switch_high_len", cyc, 5);
        highs = 0;
        repeat (10) begin
            step();
            if (clk_o) highs++;
        end
        check("switch_stays_low", highs, 0);
        $display("[TB] mode switch: D=5 high phase %0d cycles", cyc);

        // Shrink D from 8 to 2 with cnt = 6 during a high phase
        option = 1'b1; divider = 8;
        done = 1'b0; prev = clk_o;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (clk_o && !prev) done = 1'b1;
            prev = clk_o;
        end
        repeat (6) step();
        check("shrink_still_high", int'(clk_o), 1);
        divider = 2;
        step();
        check("shrink_toggle", int'(clk_o), 0);
        $display("[TB] shrink: D 8->2 at cnt=6");

        // Randomized segments checked by the scoreboard
        for (int s = 0; s < 60; s++) begin
            reset       = ($urandom_range(0, 19) == 0);
            option      = 1'($urandom_range(0, 2) == 0);
            out_enable  = 1'($urandom_range(0, 6) != 0);
            divider     = CB'($urandom_range(0, 5));
            write_pulse = 1'($urandom_range(0, 2) == 0);
            pulse       = PB'($urandom_range(0, 3));
            seg_len     = int'($urandom_range(1, 25));
            $display("[TB] seg %0d: reset=%0b option=%0b en=%0b D=%0d wp=%0b N=%0d len=%0d",
                     s, reset, option, out_enable, divider, write_pulse, pulse, seg_len);
            step();
            reset = 1'b0;
            write_pulse = 1'b0;
            repeat (seg_len) step();
        end

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
